regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter REG_SQUARE, default 23, target register for the square event source.
REQ-002 Parameter REG_TRIANGLE, default 24, target register for the triangle event source.
REQ-003 Parameter REG_STAR, default 25, target register for the star event source.
REQ-004 Parameter STARVE_LIMIT, default 8, maximum consecutive cycles pending events may be blocked by CPU writes (range 1-255).
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 ctrl_reset  input  1  reset, asynchronous, active-high.
REQ-007 cpu_we  input  1  processor writeback request.
REQ-008 cpu_reg  input  5  processor writeback register index.
REQ-009 cpu_data  input  32  processor writeback data.
REQ-010 evt_req  input  3  per-source one-cycle write request; bit0 square, bit1 triangle, bit2 star.
REQ-011 evt_data  input  96  per-source data; bits [32i+31:32i] belong to source i.
REQ-012 ctrl_writeEnable  output  1  regfile write enable.
REQ-013 ctrl_writeReg  output  5  regfile write index.
REQ-014 data_writeReg  output  32  regfile write data.
REQ-015 cpu_stall  output  1  processor write not performed this cycle; pipeline holds cpu_we/cpu_reg/cpu_data.
REQ-016 evt_busy  output  3  per-source pending buffer full.
REQ-017 evt_ack  output  3  per-source one-cycle pulse: pending value written to regfile this cycle.
REQ-018 evt_overflow  output  3  per-source sticky flag: request dropped because buffer full.

Function
REQ-019 Each source SHALL own a 1-entry pending buffer (valid bit + 32-bit data) loaded on the edge where evt_req[i]=1 and buffer free or being granted that same cycle.
REQ-020 evt_req[i]=1 while buffer i is valid and not granted that cycle SHALL drop the new data, keep the old, and set evt_overflow[i].
REQ-021 Write-port selection SHALL be combinational from current state and inputs, one winner per cycle.
REQ-022 cpu_we=1 with cpu_reg=0 SHALL produce ctrl_writeEnable=0, cpu_stall=0, and not count as a CPU write for arbitration.
REQ-023 CPU write (cpu_we=1, cpu_reg!=0) SHALL win unless starve_cnt==STARVE_LIMIT; winner drives cpu_reg/cpu_data, cpu_stall=0.
REQ-024 With no CPU write, or starve_cnt==STARVE_LIMIT, the highest-priority valid pending source SHALL win; cpu_stall=1 only if a CPU write was present.
REQ-025 Event priority SHALL be round-robin: search starts at (last_grant+1) mod 3, wrapping; last_grant updates to the winner on each event grant.
REQ-026 Event grant SHALL drive its REG_* index and buffered data, assert evt_ack[i] that cycle, clear valid at the edge (unless reloaded per REQ-019).
REQ-027 No winner SHALL give ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
REQ-028 starve_cnt (8-bit) SHALL increment when a CPU write wins and any buffer is valid, clear on any event grant or when no buffer is valid, and saturate at STARVE_LIMIT.
REQ-029 A request arriving in cycle N SHALL be writable no earlier than cycle N+1 (1-cycle capture latency); evt_busy reflects valid bits directly.
REQ-030 evt_overflow[i] SHALL clear only on reset.

Reset
REQ-031 ctrl_reset=1 SHALL asynchronously clear all valid bits, buffer data, evt_overflow, starve_cnt, and set last_grant=2 (square first).
REQ-032 During reset, ctrl_writeEnable, cpu_stall, evt_ack, evt_busy SHALL be 0; requests in reset cycles are ignored.
REQ-033 Reset mid-operation SHALL discard pending events without ack.

Verification
REQ-034 Idle CPU, evt_req=3'b001 data 0x0000_00AA in cycle 0 -> cycle 1: we=1, reg=23, data=0xAA, evt_ack=001, evt_busy=000 in cycle 2.
REQ-035 evt_req=3'b111 together, CPU idle -> writes to 23, 24, 25 in cycles 1, 2, 3, one ack each; next single request from triangle granted immediately (rotation).
REQ-036 cpu_we=1 reg=5 continuously, square pending, STARVE_LIMIT=8 -> 8 CPU writes, then cycle 9: reg=23 write, cpu_stall=1; cycle 10: CPU reg=5 write resumes.
REQ-037 Square pending, second evt_req[0] data 0x22 while CPU blocks -> evt_overflow=001, eventual write to 23 carries first data; simultaneous req and grant -> new data accepted, no overflow.
REQ-038 cpu_we=1 cpu_reg=0 with star pending -> star granted, ctrl_writeReg=25, cpu_stall=0; ctrl_reset asserted with all buffers valid -> busy=000, no ack, no write.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter. The processor writeback shares one port
// with three event sources (square, triangle, star). Each source owns a
// single-entry pending buffer. The CPU normally wins the port. Once the
// starvation counter reaches STARVE_LIMIT, the next pending event is forced
// through instead. Events are served round-robin among themselves.
module regfile_write_arbiter #(
  parameter int unsigned REG_SQUARE   = 23,
  parameter int unsigned REG_TRIANGLE = 24,
  parameter int unsigned REG_STAR     = 25,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_reg,
  input  logic [31:0] cpu_data,
  input  logic [2:0]  evt_req,
  input  logic [95:0] evt_data,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        cpu_stall,
  output logic [2:0]  evt_busy,
  output logic [2:0]  evt_ack,
  output logic [2:0]  evt_overflow
);

  typedef enum logic [1:0] {
    SRC_SQUARE   = 2'd0,
    SRC_TRIANGLE = 2'd1,
    SRC_STAR     = 2'd2
  } src_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [2:0]  valid_q, valid_d;
  logic [31:0] data_q [3];
  logic [31:0] data_d [3];
  logic [2:0]  ovf_q, ovf_d;
  logic [7:0]  starve_q, starve_d;
  src_e        last_q, last_d;

  logic        cpu_write;
  logic        any_valid;
  logic        starved;
  logic        cpu_win;
  logic        evt_win;
  src_e        win_idx;
  src_e        cand;
  logic [2:0]  evt_gnt;

  function automatic src_e next_src(input src_e s);
    case (s)
      SRC_SQUARE:   next_src = SRC_TRIANGLE;
      SRC_TRIANGLE: next_src = SRC_STAR;
      default:      next_src = SRC_SQUARE;
    endcase
  endfunction

  function automatic logic [4:0] reg_of(input src_e s);
    case (s)
      SRC_SQUARE:   reg_of = 5'(REG_SQUARE);
      SRC_TRIANGLE: reg_of = 5'(REG_TRIANGLE);
      default:      reg_of = 5'(REG_STAR);
    endcase
  endfunction

  // CPU eligibility: writes to r0 are discarded and never compete
  always_comb begin
    cpu_write = cpu_we && (cpu_reg != '0);
    any_valid = |valid_q;
    starved   = (starve_q == LIMIT) && any_valid;
    cpu_win   = cpu_write && !starved;
  end

  // Round-robin event pick, searching from the source after the last grant
  always_comb begin
    evt_win = 1'b0;
    win_idx = SRC_SQUARE;
    evt_gnt = '0;
    cand    = next_src(last_q);
    if (!cpu_win) begin
      for (int unsigned k = 0; k < 3; k++) begin
        if (!evt_win && valid_q[cand]) begin
          evt_win = 1'b1;
          win_idx = cand;
        end
        cand = next_src(cand);
      end
      if (evt_win) evt_gnt[win_idx] = 1'b1;
    end
  end

  // Write-port mux; everything is held quiet while reset is asserted
  always_comb begin
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    cpu_stall        = 1'b0;
    evt_ack          = '0;
    if (!ctrl_reset) begin
      if (cpu_win) begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = cpu_reg;
        data_writeReg    = cpu_data;
      end else if (evt_win) begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = reg_of(win_idx);
        data_writeReg    = data_q[win_idx];
        evt_ack          = evt_gnt;
        cpu_stall        = cpu_write;
      end
    end
  end

  assign evt_busy     = valid_q;
  assign evt_overflow = ovf_q;

  // Next state: a buffer being granted this cycle can accept a new request
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    starve_d = starve_q;
    last_d   = last_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (evt_req[i] && (!valid_q[i] || evt_gnt[i])) begin
        valid_d[i] = 1'b1;
        data_d[i]  = evt_data[32*i +: 32];
      end else begin
        if (evt_req[i]) ovf_d[i] = 1'b1;
        if (evt_gnt[i]) valid_d[i] = 1'b0;
      end
    end
    if (evt_win || !any_valid) begin
      starve_d = '0;
    end else if (cpu_win && (starve_q < LIMIT)) begin
      starve_d = starve_q + 8'd1;
    end
    if (evt_win) last_d = win_idx;
  end

  // State registers; reset leaves square as the first source searched
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      valid_q  <= '0;
      ovf_q    <= '0;
      starve_q <= '0;
      last_q   <= SRC_STAR;
      for (int unsigned i = 0; i < 3; i++) data_q[i] <= '0;
    end else begin
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      starve_q <= starve_d;
      last_q   <= last_d;
      for (int unsigned i = 0; i < 3; i++) data_q[i] <= data_d[i];
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: a queue-free behavioural model of the
// pending buffers is checked on every falling edge, and directed scenarios
// add literal expectations at fixed cycles.
module tb_regfile_write_arbiter;

  localparam int LIMIT = 8;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic        cpu_we = 1'b0;
  logic [4:0]  cpu_reg = '0;
  logic [31:0] cpu_data = '0;
  logic [2:0]  evt_req = '0;
  logic [95:0] evt_data = '0;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        cpu_stall;
  logic [2:0]  evt_busy;
  logic [2:0]  evt_ack;
  logic [2:0]  evt_overflow;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(
    .REG_SQUARE(23),
    .REG_TRIANGLE(24),
    .REG_STAR(25),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clock(clock),
    .ctrl_reset(ctrl_reset),
    .cpu_we(cpu_we),
    .cpu_reg(cpu_reg),
    .cpu_data(cpu_data),
    .evt_req(evt_req),
    .evt_data(evt_data),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .cpu_stall(cpu_stall),
    .evt_busy(evt_busy),
    .evt_ack(evt_ack),
    .evt_overflow(evt_overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int reg_for(input int src);
    return 23 + src;
  endfunction

  // Model state: current buffers plus the state to adopt at the next edge
  bit          m_v [3] = '{0, 0, 0};
  logic [31:0] m_d [3] = '{0, 0, 0};
  bit          m_ovf [3] = '{0, 0, 0};
  int          m_starve = 0;
  int          m_last = 2;
  bit          n_v [3];
  logic [31:0] n_d [3];
  bit          n_ovf [3];
  int          n_starve;
  int          n_last;
  bit          n_ready = 0;

  // Compare process: predict outputs from model state and present inputs
  always @(negedge clock) begin
    int win;
    int idx;
    bit cpuw;
    bit anyv;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic [2:0]  e_ack;
    logic [2:0]  e_busy;
    logic [2:0]  e_ovf;
    if (ctrl_reset) begin
      chk("rst_we", ctrl_writeEnable, 0);
      chk("rst_stall", cpu_stall, 0);
      chk("rst_ack", evt_ack, 0);
      chk("rst_busy", evt_busy, 0);
      chk("rst_ovf", evt_overflow, 0);
      for (int i = 0; i < 3; i++) begin
        m_v[i] = 0; m_d[i] = 0; m_ovf[i] = 0;
      end
      m_starve = 0;
      m_last = 2;
      n_ready = 0;
    end else begin
      cpuw = cpu_we && (cpu_reg != 0);
      anyv = m_v[0] || m_v[1] || m_v[2];
      win = -1;
      if (cpuw && !(m_starve == LIMIT && anyv)) win = 3;
      else begin
        for (int k = 1; k <= 3; k++) begin
          idx = (m_last + k) % 3;
          if (win < 0 && m_v[idx]) win = idx;
        end
      end
      e_reg = 0; e_data = 0; e_ack = 0;
      if (win == 3) begin
        e_reg = cpu_reg; e_data = cpu_data;
      end else if (win >= 0) begin
        e_reg = 5'(reg_for(win)); e_data = m_d[win]; e_ack = 3'(1 << win);
      end
      e_busy = {m_v[2], m_v[1], m_v[0]};
      e_ovf  = {m_ovf[2], m_ovf[1], m_ovf[0]};
      chk("we", ctrl_writeEnable, (win >= 0) ? 1 : 0);
      chk("reg", ctrl_writeReg, e_reg);
      chk("data", data_writeReg, e_data);
      chk("stall", cpu_stall, (cpuw && win != 3) ? 1 : 0);
      chk("ack", evt_ack, e_ack);
      chk("busy", evt_busy, e_busy);
      chk("ovf", evt_overflow, e_ovf);
      // Granted buffers drain first, so a same-cycle request refills them
      for (int i = 0; i < 3; i++) begin
        n_v[i] = m_v[i]; n_d[i] = m_d[i]; n_ovf[i] = m_ovf[i];
        if (win == i) n_v[i] = 0;
        if (evt_req[i]) begin
          if (n_v[i]) n_ovf[i] = 1;
          else begin
            n_v[i] = 1;
            n_d[i] = evt_data[32*i +: 32];
          end
        end
      end
      n_last = m_last;
      n_starve = m_starve;
      if (win >= 0 && win < 3) begin
        n_starve = 0;
        n_last = win;
      end else if (!anyv) n_starve = 0;
      else if (win == 3) n_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      n_ready = 1;
    end
  end

  always @(posedge clock) begin
    if (n_ready) begin
      for (int i = 0; i < 3; i++) begin
        m_v[i] = n_v[i]; m_d[i] = n_d[i]; m_ovf[i] = n_ovf[i];
      end
      m_starve = n_starve;
      m_last = n_last;
      n_ready = 0;
    end
  end

  // Drive one cycle's inputs just after the rising edge; return before the falling edge
  task automatic step(input bit rst, input bit we, input logic [4:0] r, input logic [31:0] d,
                      input logic [2:0] req, input logic [95:0] ed);
    @(posedge clock);
    #1;
    ctrl_reset = rst;
    cpu_we = we;
    cpu_reg = r;
    cpu_data = d;
    evt_req = req;
    evt_data = ed;
    #3;
  endtask

  task automatic idle();
    step(0, 0, 5'd0, 32'h0, 3'b000, 96'h0);
  endtask

  task automatic do_reset();
    step(1, 0, 5'd0, 32'h0, 3'b000, 96'h0);
    step(1, 0, 5'd0, 32'h0, 3'b000, 96'h0);
  endtask

  initial begin
    // Single square event with an idle CPU
    do_reset();
    step(0, 0, 5'd0, 32'h0, 3'b001, {64'h0, 32'h0000_00AA});
    chk("A_we0", ctrl_writeEnable, 0);
    idle();
    chk("A_we1", ctrl_writeEnable, 1);
    chk("A_reg1", ctrl_writeReg, 23);
    chk("A_data1", data_writeReg, 32'hAA);
    chk("A_ack1", evt_ack, 3'b001);
    idle();
    chk("A_busy2", evt_busy, 3'b000);

    // All three at once, then rotation hands triangle the next grant
    do_reset();
    step(0, 0, 5'd0, 32'h0, 3'b111, {32'hCC, 32'hBB, 32'hAA});
    idle();
    chk("B_reg1", ctrl_writeReg, 23);
    chk("B_data1", data_writeReg, 32'hAA);
    idle();
    chk("B_reg2", ctrl_writeReg, 24);
    chk("B_ack2", evt_ack, 3'b010);
    idle();
    chk("B_reg3", ctrl_writeReg, 25);
    chk("B_data3", data_writeReg, 32'hCC);
    step(0, 0, 5'd0, 32'h0, 3'b010, {32'h0, 32'hDD, 32'h0});
    idle();
    chk("B_reg5", ctrl_writeReg, 24);
    chk("B_data5", data_writeReg, 32'hDD);

    // CPU hogs the port; square forced through after LIMIT CPU writes
    do_reset();
    step(0, 1, 5'd5, 32'h55, 3'b001, {64'h0, 32'h11});
    chk("C_reg0", ctrl_writeReg, 5);
    for (int k = 1; k <= LIMIT; k++) begin
      step(0, 1, 5'd5, 32'h55, 3'b000, 96'h0);
      chk("C_cpu_reg", ctrl_writeReg, 5);
      chk("C_cpu_stall", cpu_stall, 0);
    end
    step(0, 1, 5'd5, 32'h55, 3'b000, 96'h0);
    chk("C_reg9", ctrl_writeReg, 23);
    chk("C_stall9", cpu_stall, 1);
    chk("C_ack9", evt_ack, 3'b001);
    step(0, 1, 5'd5, 32'h55, 3'b000, 96'h0);
    chk("C_reg10", ctrl_writeReg, 5);
    chk("C_stall10", cpu_stall, 0);

    // Overflow while blocked keeps the first data
    do_reset();
    step(0, 1, 5'd7, 32'h77, 3'b001, {64'h0, 32'h11});
    step(0, 1, 5'd7, 32'h77, 3'b001, {64'h0, 32'h22});
    step(0, 1, 5'd7, 32'h77, 3'b000, 96'h0);
    chk("D_ovf2", evt_overflow, 3'b001);
    for (int k = 3; k <= LIMIT; k++) step(0, 1, 5'd7, 32'h77, 3'b000, 96'h0);
    step(0, 1, 5'd7, 32'h77, 3'b000, 96'h0);
    chk("D_reg9", ctrl_writeReg, 23);
    chk("D_data9", data_writeReg, 32'h11);

    // Request coinciding with its own grant is accepted without overflow
    do_reset();
    step(0, 0, 5'd0, 32'h0, 3'b001, {64'h0, 32'h44});
    step(0, 0, 5'd0, 32'h0, 3'b001, {64'h0, 32'h66});
    chk("E_data1", data_writeReg, 32'h44);
    idle();
    chk("E_data2", data_writeReg, 32'h66);
    chk("E_ovf2", evt_overflow, 3'b000);

    // Write to r0 does not block star; reset drops full buffers silently
    do_reset();
    step(0, 0, 5'd0, 32'h0, 3'b100, {32'h77, 64'h0});
    step(0, 1, 5'd0, 32'hDEAD, 3'b000, 96'h0);
    chk("F_we1", ctrl_writeEnable, 1);
    chk("F_reg1", ctrl_writeReg, 25);
    chk("F_stall1", cpu_stall, 0);
    step(0, 0, 5'd0, 32'h0, 3'b111, {32'h3, 32'h2, 32'h1});
    step(1, 1, 5'd3, 32'h33, 3'b111, {32'h3, 32'h2, 32'h1});
    chk("F_rst_busy", evt_busy, 3'b000);
    chk("F_rst_we", ctrl_writeEnable, 0);
    chk("F_rst_ack", evt_ack, 3'b000);
    idle();
    chk("F_post_busy", evt_busy, 3'b000);
    chk("F_post_we", ctrl_writeEnable, 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
